// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: operation codes, FSM states and
// small decode helpers used by both the combinational and iterative paths.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  function automatic logic is_shift(logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  endfunction

  function automatic logic is_left_shift(logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl == ALU_SLL;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Purely combinational single-cycle ALU operations (ADD/SUB/AND/OR/SLT) and
// the zero flag; shared with the single-cycle core.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic [WIDTH-1:0]      result,
  output logic                  zero
);

  logic slt_bit;

  // Signed compare avoids the overflow trap of testing the sign of a - b.
  assign slt_bit = $signed(src_a) < $signed(src_b);

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_bit};
      // 3'b100 aliases ADD; shift codes are handled by the iterative path.
      default: result = src_a + src_b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute-stage ALU: single-cycle ops via alu_comb, shifts run
// one bit per cycle, valid/ready handshake on both request and result sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  busy
);

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] acc_reg,    acc_next;
  logic [SHW-1:0]   cnt_reg,    cnt_next;
  logic             shl_reg,    shl_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg,   zero_next;

  logic [WIDTH-1:0] comb_result;
  logic             comb_zero;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;
  logic             accept;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (comb_result),
    .zero     (comb_zero)
  );

  assign shamt   = src_b[SHW-1:0];
  assign shifted = shl_reg ? (acc_reg << 1) : (acc_reg >> 1);

  // Only combinational input-to-output path: out_ready -> in_ready.
  assign in_ready  = (state_reg == IDLE) || ((state_reg == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg == BUSY);
  assign result    = result_reg;
  assign zero      = zero_reg;

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    shl_next    = shl_reg;
    result_next = result_reg;
    zero_next   = zero_reg;

    case (state_reg)
      IDLE: state_next = IDLE;
      BUSY: begin
        acc_next = shifted;
        cnt_next = cnt_reg - SHW'(1);
        if (cnt_reg == SHW'(1)) begin
          result_next = shifted;
          zero_next   = (shifted == '0);
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // accept is only possible from IDLE or a draining HOLD, so it overrides.
    if (accept) begin
      if (is_shift(alu_ctrl)) begin
        shl_next = is_left_shift(alu_ctrl);
        if (shamt == '0) begin
          result_next = src_a;
          zero_next   = (src_a == '0);
          state_next  = HOLD;
        end else begin
          acc_next   = src_a;
          cnt_next   = shamt;
          state_next = BUSY;
        end
      end else begin
        result_next = comb_result;
        zero_next   = comb_zero;
        state_next  = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      shl_reg    <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      shl_reg    <= shl_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

endmodule
